codec_init_sequencer: RTL

//  Upstream command source for the I2C write engine. After Start, walks a fixed table
//  of codec register writes, one 7-bit register + 9-bit value per entry (codec word

---
 rtl/codec_init_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/codec_init_sequencer.sv
// Codec register init sequencer: walks a fixed table of codec writes into an I2C write engine.
// Optional completion watchdog enabled by defining INIT_TIMEOUT_EN.
module codec_init_sequencer #(
  parameter int unsigned NUM_REGS       = 11,
  parameter logic [6:0]  DEV_ADDR       = 7'h1A,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned POWERUP_WAIT   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [6:0]  cmd_addr_o,
  output logic [15:0] cmd_data_o,
  input  logic        xfer_done_i,
  input  logic        xfer_nack_i,
  output logic [3:0]  reg_index_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned WaitW  = $clog2(POWERUP_WAIT + 2);
  localparam int unsigned RetryW = $clog2(RETRY_MAX + 2);

  localparam logic [3:0]        LastIdx    = 4'(NUM_REGS - 1);
  localparam logic [WaitW-1:0]  WaitLast   = WaitW'(POWERUP_WAIT - 1);
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(RETRY_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitXfer,
    StNext,
    StPwait,
    StDone,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [15:0]       data_q, data_d;
  logic [3:0]        idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              ack_ev, nack_ev;

  // Codec word format: {register[6:0], value[8:0]}.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [15:0] word;
    unique case (idx)
      4'd0:    word = {7'd15, 9'h000};
      4'd1:    word = {7'd6,  9'h010};
      4'd2:    word = {7'd0,  9'h017};
      4'd3:    word = {7'd1,  9'h017};
      4'd4:    word = {7'd2,  9'h079};
      4'd5:    word = {7'd3,  9'h079};
      4'd6:    word = {7'd4,  9'h012};
      4'd7:    word = {7'd5,  9'h000};
      4'd8:    word = {7'd7,  9'h042};
      4'd9:    word = {7'd8,  9'h000};
      4'd10:   word = {7'd9,  9'h001};
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

`ifdef INIT_TIMEOUT_EN
  localparam int unsigned          WdW    = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [WdW-1:0]       WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout;

  // Held at zero outside WAIT_XFER, so every entry starts a fresh count.
  assign wd_d    = (state_q == StWaitXfer) ? wd_q + 1'b1 : '0;
  assign timeout = (state_q == StWaitXfer) && !xfer_done_i && (wd_q == WdLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign nack_ev = (xfer_done_i & xfer_nack_i) | timeout;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign nack_ev = xfer_done_i & xfer_nack_i;
`endif

  assign ack_ev = xfer_done_i & ~xfer_nack_i;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          retry_d = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        data_d  = table_word(idx_q);
        state_d = StIssue;
      end
      StIssue: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (cmd_ready_i) begin
          valid_d = 1'b0;
          state_d = StWaitXfer;
        end
      end
      StWaitXfer: begin
        if (ack_ev) begin
          state_d = StNext;
        end else if (nack_ev) begin
          if (retry_q < RetryLimit) begin
            retry_d = retry_q + 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StFail;
          end
        end
      end
      StNext: begin
        retry_d = '0;
        if (idx_q == 4'd0) begin
          wait_d  = '0;
          state_d = StPwait;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StLoad;
        end
      end
      StPwait: begin
        if (wait_q == WaitLast) begin
          wait_d = '0;
          if (NUM_REGS == 1) begin
            state_d = StDone;
          end else begin
            idx_d   = 4'd1;
            state_d = StLoad;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone, StFail: begin
        if (start_i) begin
          idx_d   = '0;
          retry_d = '0;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d  = !(state_d inside {StIdle, StDone, StFail});
    done_d  = (state_d == StDone);
    error_d = (state_d == StFail);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_addr_o  = DEV_ADDR;
  assign cmd_data_o  = data_q;
  assign reg_index_o = idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
